ftm_lockstep_mgr: RTL

FTM_LOCKSTEP_MGR -- requirements
Module: ftm_lockstep_mgr

---
 rtl/ftm_pkg.sv | 21 ++
 rtl/ftm_voter.sv | 41 ++++
 rtl/ftm_lockstep_mgr.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ftm_pkg.sv
// rtl/ftm_pkg.sv - shared types and widths for the lockstep manager
package ftm_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RECOVER = 2'd1,
        ST_RESET   = 2'd2
    } ftm_state_e;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] pc;
    } ftm_tuple_t;

endpackage

// File: rtl/ftm_voter.sv
// rtl/ftm_voter.sv - combinational majority vote and disagreement mask
module ftm_voter
    import ftm_pkg::*;
#(
    parameter int NCORES = 3
) (
    input  ftm_tuple_t [NCORES-1:0] tuples,
    output logic                    mismatch,
    output logic                    has_majority,
    output ftm_tuple_t              majority,
    output logic [NCORES-1:0]       faulty_mask
);

    localparam int THRESH = NCORES / 2 + 1;

    int agree;

    always_comb begin
        mismatch     = 1'b0;
        has_majority = 1'b0;
        majority     = '0;
        faulty_mask  = '1;
        agree        = 0;
        for (int i = 0; i < NCORES; i++) begin
            agree = 0;
            for (int j = 0; j < NCORES; j++) begin
                if (tuples[j] == tuples[i]) agree = agree + 1;
            end
            if (agree != NCORES) mismatch = 1'b1;
            // first core reaching the threshold names the majority tuple
            if (!has_majority && agree >= THRESH) begin
                has_majority = 1'b1;
                majority     = tuples[i];
            end
        end
        if (has_majority) begin
            for (int i = 0; i < NCORES; i++) faulty_mask[i] = (tuples[i] != majority);
        end
    end

endmodule

// File: rtl/ftm_lockstep_mgr.sv
// rtl/ftm_lockstep_mgr.sv - lockstep compare, vote and recovery sequencing
module ftm_lockstep_mgr
    import ftm_pkg::*;
#(
    parameter int NCORES      = 3,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int RST_CYC     = 8,
    parameter int CLEAN_WIN   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [NCORES-1:0]        valid_i,
    input  logic [NCORES-1:0]        we_i,
    input  logic [NCORES*ADDR_W-1:0] waddr_i,
    input  logic [NCORES*DATA_W-1:0] wdata_i,
    input  logic [NCORES*DATA_W-1:0] pc_i,
    input  logic [NCORES-1:0]        done_i,
    output logic                     recover_o,
    output logic                     recovering_o,
    output logic                     reset_o,
    output logic                     mismatch_o,
    output logic [NCORES-1:0]        faulty_mask_o,
    output logic                     voted_we_o,
    output logic [ADDR_W-1:0]        voted_waddr_o,
    output logic [DATA_W-1:0]        voted_wdata_o,
    output logic [DATA_W-1:0]        checkpoint_pc_o,
    output logic [15:0]              err_count_o,
    output logic                     error_o
);

    ftm_state_e              state, state_nx;
    ftm_tuple_t [NCORES-1:0] tuples;
    ftm_tuple_t              v_tuple;
    logic                    v_mm, v_maj;
    logic [NCORES-1:0]       v_mask;
    logic [NCORES-1:0]       done_seen;
    logic [31:0]             retry_cnt, clean_cnt, tmo_cnt, rst_cnt;
    logic                    cmp, mm_now, agree_commit, all_done, timeout, rst_done;

    always_comb begin
        tuples = '0;
        for (int i = 0; i < NCORES; i++) begin
            tuples[i].valid = valid_i[i];
            tuples[i].we    = we_i[i];
            tuples[i].waddr = we_i[i] ? waddr_i[i*ADDR_W +: ADDR_W] : '0;
            tuples[i].wdata = we_i[i] ? wdata_i[i*DATA_W +: DATA_W] : '0;
            tuples[i].pc    = valid_i[i] ? pc_i[i*DATA_W +: DATA_W] : '0;
        end
    end

    ftm_voter #(.NCORES(NCORES)) u_voter (
        .tuples       (tuples),
        .mismatch     (v_mm),
        .has_majority (v_maj),
        .majority     (v_tuple),
        .faulty_mask  (v_mask)
    );

    assign cmp          = enable_i && (state == ST_RUN) && ((|valid_i) || (|we_i));
    assign mm_now       = cmp && v_mm;
    // full agreement implies every core shares the voted valid bit
    assign agree_commit = cmp && !v_mm && v_tuple.valid;
    assign all_done     = &(done_seen | done_i);
    assign timeout      = (tmo_cnt == 32'(TIMEOUT_CYC - 1));
    assign rst_done     = (rst_cnt == 32'(RST_CYC - 1));

    always_comb begin
        state_nx     = state;
        recover_o    = 1'b0;
        recovering_o = 1'b0;
        reset_o      = 1'b0;
        case (state)
            ST_RUN: begin
                if (mm_now) state_nx = (retry_cnt == 32'(MAX_RETRY)) ? ST_RESET : ST_RECOVER;
            end
            ST_RECOVER: begin
                recover_o    = 1'b1;
                recovering_o = 1'b1;
                if (timeout)       state_nx = ST_RESET;
                else if (all_done) state_nx = ST_RUN;
            end
            ST_RESET: begin
                reset_o = 1'b1;
                if (rst_done) state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_RUN;
            mismatch_o      <= 1'b0;
            faulty_mask_o   <= '0;
            voted_we_o      <= 1'b0;
            voted_waddr_o   <= '0;
            voted_wdata_o   <= '0;
            checkpoint_pc_o <= '0;
            err_count_o     <= '0;
            error_o         <= 1'b0;
            done_seen       <= '0;
            retry_cnt       <= '0;
            clean_cnt       <= '0;
            tmo_cnt         <= '0;
            rst_cnt         <= '0;
        end else begin
            state         <= state_nx;
            mismatch_o    <= mm_now;
            faulty_mask_o <= mm_now ? v_mask : '0;
            voted_we_o    <= cmp && v_maj && v_tuple.we;
            if (cmp && v_maj) begin
                voted_waddr_o <= v_tuple.waddr;
                voted_wdata_o <= v_tuple.wdata;
            end
            if (agree_commit) checkpoint_pc_o <= v_tuple.pc;
            if (mm_now && err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;

            if (mm_now) begin
                clean_cnt <= '0;
                retry_cnt <= retry_cnt + 32'd1;
            end else if (agree_commit) begin
                if (clean_cnt == 32'(CLEAN_WIN - 1)) begin
                    clean_cnt <= '0;
                    retry_cnt <= '0;
                end else begin
                    clean_cnt <= clean_cnt + 32'd1;
                end
            end
            // entering RESET overrides the retry increment above
            if (state != ST_RESET && state_nx == ST_RESET) begin
                retry_cnt <= '0;
                error_o   <= 1'b1;
            end

            done_seen <= (state == ST_RECOVER) ? (done_seen | done_i) : '0;
            tmo_cnt   <= (state == ST_RECOVER) ? tmo_cnt + 32'd1 : '0;
            rst_cnt   <= (state == ST_RESET) ? rst_cnt + 32'd1 : '0;
        end
    end

endmodule
